// File: rtl/axis_rr_arbiter.sv
// Round-robin mux of NUM_SRC AXI-Stream sources onto one registered master port, MAX_BURST beats per grant;
// request to m_axis_tvalid takes 2 cycles, and stalls hold the output stable. `AXIS_ARB_TID_EN adds m_axis_tid.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_SRC-1:0]              s_axis_tvalid,
  output logic [NUM_SRC-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [NUM_SRC-1:0]              grant
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [$clog2(NUM_SRC)-1:0]      m_axis_tid
`endif
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SRC-1:0]     grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
`ifdef AXIS_ARB_TID_EN
  logic [IW-1:0]          tid_q, tid_d;
`endif

  logic [DATA_WIDTH-1:0]  lane [NUM_SRC];
  logic [IW:0]            cand;
  logic [IW-1:0]          cidx;
  logic [IW-1:0]          sel_idx;
  logic                   sel_vld;
  logic                   out_free;
  logic                   accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    assign lane[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Walk offsets from far to near so the source right after last_q has the final say.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    cidx    = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand = {1'b0, last_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_SRC)) cand = cand - (IW+1)'(NUM_SRC);
      cidx = cand[IW-1:0];
      if (s_axis_tvalid[cidx]) begin
        sel_vld = 1'b1;
        sel_idx = cidx;
      end
    end
  end

  assign out_free = !tvalid_q || m_axis_tready;
  assign accept   = (state_q == ST_GRANT) && s_axis_tvalid[gidx_q] && out_free;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_vld) begin
          state_d = ST_GRANT;
          grant_d = NUM_SRC'(1) << sel_idx;
          gidx_d  = sel_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (accept) cnt_d = cnt_q + 1'b1;
        // A stalled-but-valid source keeps its grant; only a dropped tvalid or a full burst releases it.
        if ((accept && cnt_q == BURST_LAST) || !s_axis_tvalid[gidx_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = gidx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ST_GRANT && out_free) s_axis_tready = grant_q;
  end

  assign grant = grant_q;

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
`ifdef AXIS_ARB_TID_EN
    tid_d    = tid_q;
`endif
    if (accept) begin
      tdata_d  = lane[gidx_q];
      tvalid_d = 1'b1;
`ifdef AXIS_ARB_TID_EN
      tid_d    = gidx_q;
`endif
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
`ifdef AXIS_ARB_TID_EN
      tid_q    <= '0;
`endif
    end else begin
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
`ifdef AXIS_ARB_TID_EN
      tid_q    <= tid_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
`ifdef AXIS_ARB_TID_EN
  assign m_axis_tid    = tid_q;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-source beat queues drive the inputs, a monitor logs output beats and grant episodes.
module tb_axis_rr_arbiter;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS*DW-1:0] s_dat;
  logic [NS-1:0]  s_vld;
  logic [NS-1:0]  s_rdy;
  logic [NS-1:0]  grant;
  logic [DW-1:0]  m_dat;
  logic           m_vld;
  logic           m_rdy;
`ifdef AXIS_ARB_TID_EN
  logic [1:0]     m_tid;
`endif

  always #5 clk = ~clk;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_dat),
    .s_axis_tvalid (s_vld),
    .s_axis_tready (s_rdy),
    .m_axis_tdata  (m_dat),
    .m_axis_tvalid (m_vld),
    .m_axis_tready (m_rdy),
    .grant         (grant)
`ifdef AXIS_ARB_TID_EN
    ,
    .m_axis_tid    (m_tid)
`endif
  );

  int errs = 0;
  int checks = 0;

  logic [7:0] sd [NS][16];
  int         sh [NS];
  int         st [NS];

  logic [7:0] out_d [64];
  logic [1:0] out_t [64];
  int         out_c [64];
  int         nout;
  int         ep_g [32];
  int         ep_n [32];
  int         ep_c [32];
  int         nep;
  int         cyc = 0;
  int         first_vld;
  logic [NS-1:0] prev_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_vld[i] = (sh[i] < st[i]);
      s_dat[i*DW +: DW] = (sh[i] < st[i]) ? sd[i][sh[i]] : 8'h00;
    end
  endtask

  task automatic push(input int s, input logic [7:0] v);
    if (st[s] < 16) begin
      sd[s][st[s]] = v;
      st[s]++;
    end
  endtask

  task automatic clear_logs();
    nout = 0;
    nep = 0;
    first_vld = -1;
    prev_g = '0;
  endtask

  // Sample handshakes at negedge, advance the sources just after the rising edge.
  task automatic step();
    logic [NS-1:0] hs;
    @(negedge clk);
    hs = s_vld & s_rdy;
    if (m_vld && m_rdy && nout < 64) begin
      out_d[nout] = m_dat;
`ifdef AXIS_ARB_TID_EN
      out_t[nout] = m_tid;
`else
      out_t[nout] = 2'd0;
`endif
      out_c[nout] = cyc;
      nout++;
    end
    if (m_vld && first_vld < 0) first_vld = cyc;
    if (grant != '0 && grant != prev_g && nep < 32) begin
      ep_g[nep] = int'(grant);
      ep_n[nep] = 0;
      ep_c[nep] = cyc;
      nep++;
    end
    if (hs != '0 && nep > 0) ep_n[nep-1]++;
    prev_g = grant;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) if (hs[i]) sh[i]++;
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_rdy = 1'b1;
    for (int i = 0; i < NS; i++) begin
      sh[i] = 0;
      st[i] = 0;
    end
    drive();
    #1;
    step();
    step();
    rst = 1'b1;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [7:0] e8;
    int eg [5];
    int en [5];
    logic [7:0] eo [10];

    // Reset values and single source at src2.
    rst = 1'b1;
    s_dat = '0;
    s_vld = '0;
    m_rdy = 1'b1;
    clear_logs();
    #3;
    do_reset();
    rst = 1'b0;
    #1;
    check("rst_m_vld", m_vld, 0);
    check("rst_m_dat", m_dat, 0);
    check("rst_grant", grant, 0);
    check("rst_s_rdy", s_rdy, 0);
    rst = 1'b1;
    push(2, 8'h11);
    push(2, 8'h22);
    push(2, 8'h33);
    drive();
    c0 = cyc;
    for (int i = 0; i < 8; i++) step();
    check("t1_grant_val", ep_g[0], 4);
    check("t1_grant_lat", ep_c[0] - c0, 1);
    check("t1_vld_lat", first_vld - c0, 2);
    check("t1_nout", nout, 3);
    check("t1_d0", out_d[0], 8'h11);
    check("t1_d1", out_d[1], 8'h22);
    check("t1_d2", out_d[2], 8'h33);
    check("t1_back2back", out_c[2] - out_c[0], 2);
    check("t1_nep", nep, 1);
    check("t1_rel_grant", grant, 0);
    check("t1_rel_vld", m_vld, 0);

    // All four sources busy: rotation 0,1,2,3,0,... with 4-beat bursts and one idle cycle.
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < 8; n++) push(s, 8'((s << 4) | n));
    drive();
    for (int i = 0; i < 50; i++) step();
    check("rr_nep", nep, 8);
    check("rr_nout", nout, 32);
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", ep_g[k], 1 << (k % 4));
      check("rr_beats", ep_n[k], 4);
      if (k < 7) check("rr_period", ep_c[k+1] - ep_c[k], 5);
      for (int b = 0; b < 4; b++) begin
        e8 = 8'(((k % 4) << 4) | ((k / 4) * 4 + b));
        check("rr_data", out_d[k*4 + b], e8);
      end
    end

    // Backpressure mid-burst from src1.
    do_reset();
    push(1, 8'hA1);
    push(1, 8'hA2);
    push(1, 8'hA3);
    push(1, 8'hA4);
    drive();
    for (int i = 0; i < 10 && nout < 1; i++) step();
    check("bp_first_beat", nout, 1);
    m_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_vld", m_vld, 1);
      check("bp_hold_dat", m_dat, 8'hA2);
      check("bp_s_rdy", s_rdy, 0);
    end
    check("bp_no_drain", nout, 1);
    m_rdy = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("bp_nout", nout, 4);
    for (int i = 0; i < 4; i++) check("bp_data", out_d[i], 8'(8'hA1 + i));

    // Early release by src3, then pointer continues from 3.
    do_reset();
    push(3, 8'h31);
    push(3, 8'h32);
    drive();
    for (int i = 0; i < 10 && nep < 1; i++) step();
    check("er_wait_g3", nep, 1);
    push(0, 8'h01);
    push(0, 8'h02);
    push(1, 8'h11);
    drive();
    for (int i = 0; i < 10 && nep < 2; i++) step();
    check("er_wait_g0", nep, 2);
    for (int n = 0; n < 5; n++) push(3, 8'(8'h33 + n));
    drive();
    for (int i = 0; i < 30; i++) step();
    eg = '{8, 1, 2, 8, 8};
    en = '{2, 2, 1, 4, 1};
    eo = '{8'h31, 8'h32, 8'h01, 8'h02, 8'h11, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    check("er_nep", nep, 5);
    for (int k = 0; k < 5; k++) begin
      check("er_grant", ep_g[k], eg[k]);
      check("er_beats", ep_n[k], en[k]);
    end
    check("er_nout", nout, 10);
    for (int i = 0; i < 10; i++) check("er_data", out_d[i], eo[i]);

    // Reset in the middle of a src1 burst.
    do_reset();
    for (int n = 0; n < 4; n++) push(1, 8'(8'hB1 + n));
    drive();
    for (int i = 0; i < 10 && !(grant == 4'b0010 && m_vld); i++) step();
    check("mr_reached", (grant == 4'b0010 && m_vld), 1);
    rst = 1'b0;
    #1;
    check("mr_m_vld", m_vld, 0);
    check("mr_m_dat", m_dat, 0);
    check("mr_grant", grant, 0);
    check("mr_s_rdy", s_rdy, 0);
    do_reset();
    push(1, 8'h1B);
    push(0, 8'h0A);
    drive();
    for (int i = 0; i < 10; i++) step();
    check("mr_first_grant", ep_g[0], 1);
    check("mr_nout", nout, 2);
    check("mr_d0", out_d[0], 8'h0A);
    check("mr_d1", out_d[1], 8'h1B);

`ifdef AXIS_ARB_TID_EN
    do_reset();
    push(1, 8'h5A);
    push(3, 8'h6B);
    drive();
    for (int i = 0; i < 10; i++) step();
    check("tid_nout", nout, 2);
    check("tid_d0", out_d[0], 8'h5A);
    check("tid_t0", out_t[0], 1);
    check("tid_d1", out_d[1], 8'h6B);
    check("tid_t1", out_t[1], 3);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
